fetch: RTL and testbench

Instruction-fetch front end producing the `fetched_inst0`/`fetched_inst0_pc` pair consumed by the Decode stage. It holds the program counter and issues in-order requests to instruction memory. Responses go into a small in-order buffer, and the buffer head is presented to Decode under Decode's `stall`/`kill` protocol. When no instruction is ready, the block inserts a NOP bubble, because Decode has no valid input.

---
 rtl/fetch.sv | 120 ++++++++++++
 tb/tb_fetch.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// Instruction-fetch front end: PC, in-order imem requests, small response buffer, Decode handoff.
// Optional JAL target prediction is enabled by defining FETCH_JAL_PREDICT_EN.
module fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        kill,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] fetched_inst0,
   output logic [31:0] fetched_inst0_pc,
   output logic        fetched_valid
);

   localparam int          IDX_W = $clog2(BUF_DEPTH);
   localparam int          PTR_W = IDX_W + 1;
   localparam int          CNT_W = IDX_W + 2;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic [PTR_W-1:0] alloc_ptr_reg, fill_ptr_reg, head_ptr_reg;
   logic [31:0]      pc_reg;
   logic [CNT_W-1:0] inflight_reg, drop_reg;
   logic [BUF_DEPTH-1:0] filled_reg;
   logic [31:0]      entry_pc_reg   [BUF_DEPTH];
   logic [31:0]      entry_inst_reg [BUF_DEPTH];

   logic [PTR_W-1:0] used;
   logic [IDX_W-1:0] alloc_idx, fill_idx, head_idx;
   logic             full, grant, resp_drop, resp_fill, pop, head_filled;

   assign used        = alloc_ptr_reg - head_ptr_reg;
   assign full        = (used == PTR_W'(BUF_DEPTH));
   assign alloc_idx   = alloc_ptr_reg[IDX_W-1:0];
   assign fill_idx    = fill_ptr_reg[IDX_W-1:0];
   assign head_idx    = head_ptr_reg[IDX_W-1:0];
   assign head_filled = filled_reg[head_idx];

   assign imem_req  = !reset && !kill && !full;
   assign imem_addr = pc_reg;
   assign grant     = imem_req && imem_gnt;
   assign resp_drop = imem_rvalid && (drop_reg != '0);
   assign resp_fill = imem_rvalid && (drop_reg == '0);
   assign pop       = !stall && !kill && head_filled;

   assign fetched_valid    = head_filled;
   assign fetched_inst0    = head_filled ? entry_inst_reg[head_idx] : NOP;
   assign fetched_inst0_pc = head_filled ? entry_pc_reg[head_idx]   : 32'h0;

`ifdef FETCH_JAL_PREDICT_EN
   logic             jal_hit;
   logic [31:0]      jal_target;
   logic [PTR_W-1:0] jal_freed;

   assign jal_hit    = resp_fill && (imem_rdata[6:0] == 7'b1101111);
   assign jal_target = entry_pc_reg[fill_idx] + {{11{imem_rdata[31]}}, imem_rdata[31],
                       imem_rdata[19:12], imem_rdata[20], imem_rdata[30:21], 1'b0};
   // Entries younger than the JAL, including one granted this very cycle.
   assign jal_freed  = alloc_ptr_reg + PTR_W'(grant) - fill_ptr_reg - PTR_W'(1);
`endif

   always_ff @(posedge clk) begin
      if (grant)
         entry_pc_reg[alloc_idx] <= pc_reg;
      if (resp_fill)
         entry_inst_reg[fill_idx] <= imem_rdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         alloc_ptr_reg <= '0;
         fill_ptr_reg  <= '0;
         head_ptr_reg  <= '0;
         filled_reg    <= '0;
         pc_reg        <= RESET_PC;
         inflight_reg  <= '0;
         drop_reg      <= '0;
      end else begin
         inflight_reg <= inflight_reg + CNT_W'(grant) - CNT_W'(imem_rvalid);
         if (kill) begin
            alloc_ptr_reg <= head_ptr_reg;
            fill_ptr_reg  <= head_ptr_reg;
            filled_reg    <= '0;
            pc_reg        <= redirect_pc;
            // inflight already includes responses that are stale, so it alone is the outstanding total.
            drop_reg      <= inflight_reg - CNT_W'(imem_rvalid);
         end else begin
            if (grant) begin
               alloc_ptr_reg         <= alloc_ptr_reg + PTR_W'(1);
               pc_reg                <= pc_reg + 32'd4;
               filled_reg[alloc_idx] <= 1'b0;
            end
            if (resp_drop)
               drop_reg <= drop_reg - CNT_W'(1);
            if (resp_fill) begin
               filled_reg[fill_idx] <= 1'b1;
               fill_ptr_reg         <= fill_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
               filled_reg[head_idx] <= 1'b0;
               head_ptr_reg         <= head_ptr_reg + PTR_W'(1);
            end
`ifdef FETCH_JAL_PREDICT_EN
            if (jal_hit) begin
               alloc_ptr_reg <= fill_ptr_reg + PTR_W'(1);
               pc_reg        <= jal_target;
               drop_reg      <= drop_reg + CNT_W'(jal_freed);
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: memory model plus scoreboard of expected (pc, filled) entries.
// Build with FETCH_JAL_PREDICT_EN defined to also exercise the JAL prediction scenario.
module tb_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] NO_JAL = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset, stall, kill;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt, imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] fetched_inst0, fetched_inst0_pc;
   logic        fetched_valid;

   always #5 clk = ~clk;

   fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .stall(stall), .kill(kill), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .fetched_inst0(fetched_inst0), .fetched_inst0_pc(fetched_inst0_pc),
      .fetched_valid(fetched_valid)
   );

   typedef struct { logic [31:0] pc; int id; bit filled; } exp_t;
   typedef struct { logic [31:0] addr; int id; bit live; int due; } mem_t;

   exp_t sb[$];
   mem_t mq[$];
   int checks = 0, failures = 0, cyc = 0, next_id = 0, lat = 1;
   bit alt_gnt = 1'b0;
   logic [31:0] model_pc = 32'h0;
   logic [31:0] jal_addr = NO_JAL;
   logic [31:0] jal_word = 32'h0200_006F;   // jal x0, +32
   logic [31:0] jal_dest = 32'h0000_0028;
   logic        last_valid, last_req;
   logic [31:0] last_pc, last_inst, last_addr;

   // Memory returns the address as data, except for the planted JAL word.
   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a == jal_addr) ? jal_word : a;
   endfunction

   task automatic step(input bit rst_i, input bit stall_i, input bit kill_i, input logic [31:0] redir_i);
      bit exp_req, exp_valid, do_grant, do_pop, have_r, jal_hit;
      int jal_id;
      mem_t r;
      @(negedge clk);
      reset = rst_i; stall = stall_i; kill = kill_i; redirect_pc = redir_i;
      imem_gnt = alt_gnt ? ((cyc % 2) == 0) : 1'b1;
      have_r = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      jal_hit = 1'b0; jal_id = 0;
      if (!rst_i && mq.size() > 0 && mq[0].due <= cyc) begin
         r = mq.pop_front();
         have_r = 1'b1; imem_rvalid = 1'b1; imem_rdata = mem_data(r.addr);
      end
      #1;
      last_valid = fetched_valid; last_pc = fetched_inst0_pc; last_inst = fetched_inst0;
      last_req = imem_req; last_addr = imem_addr;
      exp_req = !rst_i && !kill_i && (sb.size() < 4);
      checks++;
      if (imem_req !== exp_req) begin
         failures++; $display("FAIL req cyc=%0d got=%b exp=%b", cyc, imem_req, exp_req);
      end
      exp_valid = (sb.size() > 0) && sb[0].filled;
      checks++;
      if (fetched_valid !== exp_valid) begin
         failures++; $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, fetched_valid, exp_valid);
      end
      if (exp_valid) begin
         checks++;
         if (fetched_inst0_pc !== sb[0].pc || fetched_inst0 !== mem_data(sb[0].pc)) begin
            failures++;
            $display("FAIL head cyc=%0d got pc=%h inst=%h exp pc=%h inst=%h", cyc,
                     fetched_inst0_pc, fetched_inst0, sb[0].pc, mem_data(sb[0].pc));
         end
      end else begin
         checks++;
         if (fetched_inst0 !== NOP || fetched_inst0_pc !== 32'h0) begin
            failures++;
            $display("FAIL bubble cyc=%0d got pc=%h inst=%h exp pc=0 inst=%h", cyc,
                     fetched_inst0_pc, fetched_inst0, NOP);
         end
      end
      do_grant = imem_req && imem_gnt;
      if (do_grant) begin
         checks++;
         if (imem_addr !== model_pc) begin
            failures++; $display("FAIL addr cyc=%0d got=%h exp=%h", cyc, imem_addr, model_pc);
         end
      end
      if (rst_i) begin
         sb.delete(); mq.delete(); model_pc = 32'h0;
      end else begin
         do_pop = !stall_i && !kill_i && exp_valid;
         if (have_r && r.live) begin
            foreach (sb[i]) if (sb[i].id == r.id) sb[i].filled = 1'b1;
`ifdef FETCH_JAL_PREDICT_EN
            if (mem_data(r.addr) == jal_word) begin jal_hit = 1'b1; jal_id = r.id; end
`endif
         end
         if (do_grant) begin
            mq.push_back('{addr: imem_addr, id: next_id, live: 1'b1, due: cyc + lat});
            sb.push_back('{pc: model_pc, id: next_id, filled: 1'b0});
            next_id++; model_pc += 32'd4;
         end
         if (do_pop) void'(sb.pop_front());
         if (jal_hit && !kill_i) begin
            while (sb.size() > 0 && sb[$].id > jal_id) void'(sb.pop_back());
            foreach (mq[i]) if (mq[i].id > jal_id) mq[i].live = 1'b0;
            model_pc = jal_dest;
         end
         if (kill_i) begin
            sb.delete();
            foreach (mq[i]) mq[i].live = 1'b0;
            model_pc = redir_i;
         end
      end
      cyc++;
   endtask

   task automatic test_reset();
      reset = 1'b1; stall = 1'b0; kill = 1'b0; redirect_pc = 32'h0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      step(1, 0, 0, 32'h0);
      checks++;
      if (last_valid !== 1'b0 || last_inst !== NOP || last_pc !== 32'h0 || last_req !== 1'b0) begin
         failures++;
         $display("FAIL reset_state got v=%b inst=%h pc=%h req=%b exp v=0 inst=%h pc=0 req=0",
                  last_valid, last_inst, last_pc, last_req, NOP);
      end
   endtask

   task automatic test_stream();
      int nvalid = 0, first = -1;
      lat = 1; alt_gnt = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step(0, 0, 0, 32'h0);
         if (last_valid) begin
            if (first < 0) first = i;
            nvalid++;
         end
      end
      checks++;
      if (first != 2 || nvalid != 10) begin
         failures++; $display("FAIL stream got first=%0d n=%0d exp first=2 n=10", first, nvalid);
      end
   endtask

   task automatic test_stall();
      logic [31:0] held_pc;
      int req_low = 0;
      for (int i = 0; i < 6; i++) begin
         step(0, 1, 0, 32'h0);
         if (i == 0) held_pc = last_pc;
         if (!last_req) req_low++;
         checks++;
         if (last_pc !== held_pc || last_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold cyc=%0d got pc=%h v=%b exp pc=%h v=1", cyc, last_pc, last_valid, held_pc);
         end
      end
      checks++;
      if (req_low == 0) begin
         failures++; $display("FAIL stall_full got req_low=%0d exp >0", req_low);
      end
      repeat (10) step(0, 0, 0, 32'h0);
   endtask

   task automatic test_kill();
      int bubbles = 0;
      logic [31:0] first_pc = 32'hDEAD_BEEF;
      lat = 3;
      repeat (5) step(0, 0, 0, 32'h0);
      step(0, 0, 1, 32'h0000_0100);
      for (int i = 0; i < 16; i++) begin
         step(0, 0, 0, 32'h0);
         if (first_pc == 32'hDEAD_BEEF) begin
            if (last_valid) first_pc = last_pc;
            else bubbles++;
         end
      end
      checks++;
      if (first_pc !== 32'h0000_0100 || bubbles == 0) begin
         failures++; $display("FAIL kill got first_pc=%h bubbles=%0d exp first_pc=100 bubbles>0", first_pc, bubbles);
      end
   endtask

   task automatic test_slow();
      int nvalid = 0, bubbles = 0;
      lat = 3; alt_gnt = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step(0, (i % 7) == 3, 0, 32'h0);
         if (last_valid) nvalid++; else bubbles++;
      end
      alt_gnt = 1'b0;
      checks++;
      if (bubbles == 0 || nvalid < 5) begin
         failures++; $display("FAIL slow got valid=%0d bubbles=%0d exp valid>=5 bubbles>0", nvalid, bubbles);
      end
   endtask

`ifdef FETCH_JAL_PREDICT_EN
   task automatic test_jal();
      logic [31:0] seen[$];
      int idx = -1;
      bit bad = 1'b0;
      jal_addr = 32'h0000_0008; lat = 1; alt_gnt = 1'b0;
      repeat (2) step(1, 0, 0, 32'h0);
      for (int i = 0; i < 14; i++) begin
         step(0, 0, 0, 32'h0);
         if (last_valid) seen.push_back(last_pc);
      end
      foreach (seen[i]) begin
         if (seen[i] == 32'h8 && idx < 0) idx = i;
         if (seen[i] == 32'hC || seen[i] == 32'h10) bad = 1'b1;
      end
      checks++;
      if (idx < 0 || idx + 1 >= seen.size() || bad) begin
         failures++; $display("FAIL jal_seq got idx=%0d n=%0d skipped_seen=%b exp idx>=0 skipped_seen=0", idx, seen.size(), bad);
      end else if (seen[idx + 1] !== jal_dest) begin
         failures++; $display("FAIL jal_seq got next=%h exp next=%h", seen[idx + 1], jal_dest);
      end
      repeat (2) step(1, 0, 0, 32'h0);
      jal_addr = NO_JAL;
   endtask
`endif

   task automatic test_reset_mid();
      lat = 1; alt_gnt = 1'b0;
      repeat (6) step(0, 1, 0, 32'h0);
      step(1, 1, 0, 32'h0);
      step(1, 1, 0, 32'h0);
      checks++;
      if (last_valid !== 1'b0 || last_inst !== NOP || last_pc !== 32'h0 || last_req !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid got v=%b inst=%h pc=%h req=%b exp v=0 inst=%h pc=0 req=0",
                  last_valid, last_inst, last_pc, last_req, NOP);
      end
      step(0, 0, 0, 32'h0);
      checks++;
      if (last_req !== 1'b1 || last_addr !== 32'h0) begin
         failures++; $display("FAIL reset_restart got req=%b addr=%h exp req=1 addr=0", last_req, last_addr);
      end
      repeat (8) step(0, 0, 0, 32'h0);
   endtask

   task automatic test_drain();
      int budget = 0;
      lat = 1;
      while (sb.size() > 0 && budget < 50) begin
         step(0, 0, 0, 32'h0);
         budget++;
         if (sb.size() < 4) break;
      end
      checks++;
      if (budget >= 50) begin
         failures++; $display("FAIL drain got budget=%0d exp <50", budget);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_kill();
      test_slow();
`ifdef FETCH_JAL_PREDICT_EN
      test_jal();
`endif
      test_reset_mid();
      test_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
